// File: rtl/nibble_serial_adder_ctrl.sv
// Serial 32-bit adder: one shared 4-bit carry-increment slice, one nibble per clock, LSB first.
// Operands and result use valid/ready handshakes. The result carries cout and ovf flags.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0] w_a_nib;
    logic [3:0] w_b_nib;
    logic [4:0] w_t;
    logic [3:0] w_nib;
    logic       w_c_inc;
    logic       w_carry_next;
    logic       w_last;
    logic       w_ovf;

    // Shared slice: carry-free nibble add, then a conditional +1 when carry is pending.
    assign w_a_nib      = r_a[{r_k, 2'b00} +: 4];
    assign w_b_nib      = r_b[{r_k, 2'b00} +: 4];
    assign w_t          = {1'b0, w_a_nib} + {1'b0, w_b_nib};
    assign w_nib        = w_t[3:0] + {3'b000, r_carry};
    assign w_c_inc      = r_carry & (w_t[3:0] == 4'hF);
    assign w_carry_next = w_t[4] | w_c_inc;
    assign w_last       = (r_k == KW'(NIB - 1));
    // On the last slice, w_nib[3] is the new sum MSB.
    assign w_ovf        = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_nib[3] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_k     <= '0;
                        r_sum   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_sum[{r_k, 2'b00} +: 4] <= w_nib;
                    r_carry                  <= w_carry_next;
                    if (w_last) begin
                        r_cout  <= w_carry_next;
                        r_ovf   <= w_ovf;
                        r_state <= StDone;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state != StIdle);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed scenarios plus a random sweep,
// all checked against a plain-arithmetic reference of a+b+cin.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_a        (a),
        .i_b        (b),
        .i_cin      (cin),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_sum      (sum),
        .o_cout     (cout),
        .o_ovf      (ovf),
        .o_busy     (busy)
    );

    // Reference: {ovf, cout, sum} from 33-bit integer addition.
    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        logic [32:0] full;
        logic        v;
        full = {1'b0, x} + {1'b0, y} + {32'd0, c};
        v    = (x[31] == y[31]) && (full[31] != x[31]);
        return {v, full[32], full[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE; returns the presented result and acceptance-to-valid latency.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                          input int stall, output logic [31:0] s, output logic co,
                          output logic v, output int lat);
        a = x; b = y; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) tick();
        s = sum; co = cout; v = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        n_cmp++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, cout, ovf, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] xs[3] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] ys[3] = '{32'h00000000, 32'h00000001, 32'h80000000};
        logic        cs[3] = '{1'b1, 1'b0, 1'b0};
        logic [33:0] want[3] = '{{1'b0, 1'b1, 32'h0}, {1'b1, 1'b0, 32'h80000000},
                                 {1'b1, 1'b1, 32'h0}};
        logic [31:0] s;
        logic        co, v;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(xs[i], ys[i], cs[i], 0, s, co, v, lat);
            n_cmp++;
            if ({v, co, s} !== want[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got ovf=%b cout=%b sum=%h, want %h", i, v, co, s, want[i]);
            end
            n_cmp++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL directed_latency_%0d: got %0d, want 8", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int t;
        a = 32'h12345678; b = 32'h9ABCDEF0; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h01010101;
        t = 0;
        for (int i = 0; i < 3; i++) begin tick(); t++; end
        in_valid = 1'b1; a = 32'h1; b = 32'h1;
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_run_ready: got rdy=%b busy=%b, want 0 1", in_ready, busy);
        end
        tick(); t++;
        in_valid = 1'b0;
        while (!out_valid && t < 50) begin tick(); t++; end
        n_cmp++;
        if (t !== 8) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d, want 8", t);
        end
        in_valid = 1'b1; a = $urandom; b = $urandom;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || sum !== 32'hACF13568 || cout !== 1'b0 || ovf !== 1'b0
                || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b sum=%h cout=%b ovf=%b rdy=%b, want 1 acf13568 0 0 0",
                         i, out_valid, sum, cout, ovf, in_ready);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_late_accept: got rdy=%b, want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[2], pb[2], rs[2];
        logic        pc[2], rc[2], rv[2];
        logic [33:0] want;
        int          acc[2];
        int          n_acc = 0, n_res = 0;
        for (int i = 0; i < 2; i++) begin
            pa[i] = $urandom; pb[i] = $urandom; pc[i] = 1'($urandom);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n_res < 2; cyc++) begin
            if (out_valid) begin
                rs[n_res] = sum; rc[n_res] = cout; rv[n_res] = ovf; n_res++;
            end
            if (n_acc == 2) begin
                in_valid = 1'b0;
            end else if (in_ready) begin
                a = pa[n_acc]; b = pb[n_acc]; cin = pc[n_acc];
                acc[n_acc] = cyc; n_acc++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (n_res !== 2 || n_acc !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got acc=%0d res=%0d, want 2 2", n_acc, n_res);
        end else begin
            n_cmp++;
            if (acc[1] - acc[0] !== 10) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d, want 10", acc[1] - acc[0]);
            end
            for (int i = 0; i < 2; i++) begin
                want = ref_add(pa[i], pb[i], pc[i]);
                n_cmp++;
                if ({rv[i], rc[i], rs[i]} !== want) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: got %h, want %h", i, {rv[i], rc[i], rs[i]}, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s;
        logic        co, v, seen;
        int          lat;
        a = 32'h11111111; b = 32'h22222222; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, cout, ovf, sum);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_stale: got stale activity=%b, want 0", seen);
        end
        run_op(32'd5, 32'd7, 1'b0, 1, s, co, v, lat);
        n_cmp++;
        if (s !== 32'd12 || co !== 1'b0 || v !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL midrun_new_op: got sum=%0d cout=%b ovf=%b lat=%0d, want 12 0 0 8",
                     s, co, v, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, s;
        logic        c, co, v;
        logic [33:0] want;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom; y = $urandom; c = 1'($urandom);
            case ($urandom_range(0, 7))
                0: x = 32'hFFFFFFFF;
                1: y = ~x;
                2: x = 32'h80000000;
                default: ;
            endcase
            want = ref_add(x, y, c);
            run_op(x, y, c, $urandom_range(0, 3), s, co, v, lat);
            n_cmp++;
            if ({v, co, s} !== want) begin
                n_fail++;
                $display("FAIL random_result_%0d: a=%h b=%h cin=%b got %h, want %h",
                         i, x, y, c, {v, co, s}, want);
            end
            n_cmp++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL random_latency_%0d: got %0d, want 8", i, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
